// File: rtl/sim_pkg.sv
// Shared types and geometry constants for the elevator simulation.
package sim_pkg;

  // Global simulation phase driven by the game controller.
  typedef enum logic [1:0] {
    SIM_START  = 2'd0,
    SIM_RUN    = 2'd1,
    SIM_PAUSE  = 2'd2,
    SIM_ENDING = 2'd3
  } sim_state_e;

  // Life cycle of one passenger slot.
  typedef enum logic [2:0] {
    P_IDLE     = 3'd0,
    P_WALK_IN  = 3'd1,
    P_WAIT     = 3'd2,
    P_RIDE     = 3'd3,
    P_WALK_OUT = 3'd4
  } pass_state_e;

  // Screen geometry in pixels.
  localparam int X_MAX      = 639;
  localparam int DOOR_X0    = 300;
  localparam int DOOR_PITCH = 40;
  localparam int EXIT_L     = 45;
  localparam int EXIT_R     = 595;

endpackage

// File: rtl/passenger_slot.sv
// One passenger: life-cycle FSM plus registered screen position.
module passenger_slot
  import sim_pkg::*;
#(
  parameter int FLOORS    = 6,
  parameter int ELEVATORS = 2,
  parameter int XW        = 10,
  parameter int FW        = 3,
  parameter int EW        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  input  logic              tick,
  input  logic [1:0]        sim_speed,
  input  logic              spawn,
  input  logic [21:0]       rnd,
  input  logic [FW-1:0]     car_floor,
  input  logic              car_door,
  input  logic              board,
  output pass_state_e       state,
  output logic [XW-1:0]     xpos,
  output logic [FW-1:0]     ypos,
  output logic [FW-1:0]     orig,
  output logic [FW-1:0]     dest,
  output logic [EW-1:0]     car,
  output logic              board_req,
  output logic              alight,
  output logic              done
);

  pass_state_e   state_r, state_nxt_s;
  logic [XW-1:0] x_r, x_nxt_s;
  logic [FW-1:0] y_r, y_nxt_s;
  logic [FW-1:0] orig_r, orig_nxt_s;
  logic [FW-1:0] dest_r, dest_nxt_s;
  logic [EW-1:0] car_r, car_nxt_s;
  logic          side_r, side_nxt_s;

  // Spawn decode of the random word; dest is offset so it never equals orig.
  logic [7:0]    orig_full_s;
  logic [7:0]    off_full_s;
  logic [8:0]    dsum_s;
  logic [8:0]    dmod_s;
  logic [4:0]    car_full_s;

  assign orig_full_s = rnd[7:0] % 8'(FLOORS);
  assign off_full_s  = rnd[15:8] % 8'(FLOORS - 1);
  assign dsum_s      = {1'b0, orig_full_s} + 9'd1 + {1'b0, off_full_s};
  assign dmod_s      = dsum_s % 9'(FLOORS);
  assign car_full_s  = {1'b0, rnd[19:16]} % 5'(ELEVATORS);

  // Walk geometry: target, distance to go, and one step toward it.
  logic [XW-1:0] door_x_s;
  logic [XW-1:0] target_s;
  logic [XW-1:0] speed_x_s;
  logic [XW-1:0] diff_s;
  logic [XW-1:0] step_x_s;
  logic          arrive_s;

  assign door_x_s  = XW'(DOOR_X0) + XW'(DOOR_PITCH) * XW'(car_r);
  assign target_s  = (state_r == P_WALK_OUT) ? (side_r ? XW'(EXIT_R) : XW'(EXIT_L)) : door_x_s;
  assign speed_x_s = XW'(sim_speed);
  assign diff_s    = (x_r > target_s) ? (x_r - target_s) : (target_s - x_r);
  assign arrive_s  = (diff_s <= speed_x_s);
  assign step_x_s  = (x_r < target_s) ? (x_r + speed_x_s) : (x_r - speed_x_s);

  assign board_req = run && (state_r == P_WAIT) && (car_floor == orig_r) && car_door;
  assign alight    = run && (state_r == P_RIDE) && (car_floor == dest_r) && car_door;
  assign done      = run && tick && (state_r == P_WALK_OUT) && arrive_s;

  assign state = state_r;
  assign xpos  = x_r;
  assign ypos  = y_r;
  assign orig  = orig_r;
  assign dest  = dest_r;
  assign car   = car_r;

  // Next-state and next-position logic for the passenger.
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    orig_nxt_s  = orig_r;
    dest_nxt_s  = dest_r;
    car_nxt_s   = car_r;
    side_nxt_s  = side_r;
    if (clear) begin
      state_nxt_s = P_IDLE;
      x_nxt_s     = '0;
      y_nxt_s     = '0;
      orig_nxt_s  = '0;
      dest_nxt_s  = '0;
      car_nxt_s   = '0;
      side_nxt_s  = 1'b0;
    end else if (run) begin
      case (state_r)
        P_IDLE: begin
          if (spawn) begin
            state_nxt_s = P_WALK_IN;
            orig_nxt_s  = FW'(orig_full_s);
            dest_nxt_s  = FW'(dmod_s);
            car_nxt_s   = EW'(car_full_s);
            x_nxt_s     = rnd[20] ? XW'(X_MAX) : '0;
            y_nxt_s     = FW'(orig_full_s);
            side_nxt_s  = rnd[21];
          end else begin
            state_nxt_s = P_IDLE;
          end
        end
        P_WALK_IN: begin
          if (tick && arrive_s) begin
            x_nxt_s     = target_s;
            state_nxt_s = P_WAIT;
          end else if (tick) begin
            x_nxt_s = step_x_s;
          end else begin
            x_nxt_s = x_r;
          end
        end
        P_WAIT: begin
          if (board) begin
            state_nxt_s = P_RIDE;
          end else begin
            state_nxt_s = P_WAIT;
          end
        end
        P_RIDE: begin
          if (alight) begin
            state_nxt_s = P_WALK_OUT;
            y_nxt_s     = dest_r;
          end else begin
            y_nxt_s = car_floor;
          end
        end
        P_WALK_OUT: begin
          if (tick && arrive_s) begin
            state_nxt_s = P_IDLE;
            x_nxt_s     = '0;
            y_nxt_s     = '0;
          end else if (tick) begin
            x_nxt_s = step_x_s;
          end else begin
            x_nxt_s = x_r;
          end
        end
        default: begin
          state_nxt_s = P_IDLE;
          x_nxt_s     = '0;
          y_nxt_s     = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Passenger state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= P_IDLE;
      x_r     <= '0;
      y_r     <= '0;
      orig_r  <= '0;
      dest_r  <= '0;
      car_r   <= '0;
      side_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      orig_r  <= orig_nxt_s;
      dest_r  <= dest_nxt_s;
      car_r   <= car_nxt_s;
      side_r  <= side_nxt_s;
    end
  end

endmodule

// File: rtl/passenger_pool.sv
// Pool of passenger slots: spawn priority, per-car boarding arbiter and counters.
module passenger_pool
  import sim_pkg::*;
#(
  parameter int  SLOTS     = 8,
  parameter int  FLOORS    = 6,
  parameter int  ELEVATORS = 2,
  parameter int  CAP       = 4,
  parameter int  XW        = 10,
  localparam int FW        = $clog2(FLOORS),
  localparam int EW        = (ELEVATORS > 1) ? $clog2(ELEVATORS) : 1,
  localparam int CW        = $clog2(CAP + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                sim_state,
  input  logic [1:0]                sim_speed,
  input  logic                      tick,
  input  logic                      spawn_en,
  input  logic [21:0]               rnd,
  input  logic [ELEVATORS*FW-1:0]   elev_floor,
  input  logic [ELEVATORS-1:0]      door_open,
  output logic [SLOTS*XW-1:0]       xpos,
  output logic [SLOTS*FW-1:0]       ypos,
  output logic [SLOTS-1:0]          slot_active,
  output logic [ELEVATORS*FLOORS-1:0] hall_req,
  output logic [ELEVATORS*FLOORS-1:0] car_req,
  output logic [ELEVATORS*CW-1:0]   rider_count,
  output logic [15:0]               delivered
);

  sim_state_e    sim_s;
  logic          run_s;
  logic          clear_s;

  assign sim_s   = sim_state_e'(sim_state);
  assign run_s   = (sim_s == SIM_RUN);
  assign clear_s = (sim_s == SIM_START) || (sim_s == SIM_ENDING);

  pass_state_e   st_s       [SLOTS];
  logic [FW-1:0] orig_s     [SLOTS];
  logic [FW-1:0] dest_s     [SLOTS];
  logic [EW-1:0] car_s      [SLOTS];
  logic [FW-1:0] car_floor_s[SLOTS];
  logic [SLOTS-1:0] car_door_s;
  logic [SLOTS-1:0] spawn_s;
  logic [SLOTS-1:0] req_s;
  logic [SLOTS-1:0] grant_s;
  logic [SLOTS-1:0] alight_s;
  logic [SLOTS-1:0] done_s;
  logic             found_s;
  logic             taken_s;

  logic [CW-1:0] count_r    [ELEVATORS];
  logic [CW-1:0] count_nxt_s[ELEVATORS];
  logic [15:0]   delivered_r;
  logic [7:0]    n_done_s;
  logic [16:0]   dsum_s;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    passenger_slot #(
      .FLOORS   (FLOORS),
      .ELEVATORS(ELEVATORS),
      .XW       (XW),
      .FW       (FW),
      .EW       (EW)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_s),
      .run      (run_s),
      .tick     (tick),
      .sim_speed(sim_speed),
      .spawn    (spawn_s[i]),
      .rnd      (rnd),
      .car_floor(car_floor_s[i]),
      .car_door (car_door_s[i]),
      .board    (grant_s[i]),
      .state    (st_s[i]),
      .xpos     (xpos[i*XW +: XW]),
      .ypos     (ypos[i*FW +: FW]),
      .orig     (orig_s[i]),
      .dest     (dest_s[i]),
      .car      (car_s[i]),
      .board_req(req_s[i]),
      .alight   (alight_s[i]),
      .done     (done_s[i])
    );
    assign slot_active[i] = (st_s[i] != P_IDLE);
  end

  for (genvar e = 0; e < ELEVATORS; e++) begin : g_cnt
    assign rider_count[e*CW +: CW] = count_r[e];
  end

  assign delivered = delivered_r;

  // Lowest-index idle slot takes the spawn request; drop it when none are idle.
  always_comb begin
    spawn_s = '0;
    found_s = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      spawn_s[i] = run_s && spawn_en && (st_s[i] == P_IDLE) && !found_s;
      found_s    = found_s | spawn_s[i];
    end
  end

  // Route each slot's assigned car floor and door status back to it.
  always_comb begin
    car_door_s = '0;
    for (int i = 0; i < SLOTS; i++) begin
      car_floor_s[i] = '0;
      for (int e = 0; e < ELEVATORS; e++) begin
        car_floor_s[i] = (car_s[i] == EW'(e)) ? elev_floor[e*FW +: FW] : car_floor_s[i];
        car_door_s[i]  = (car_s[i] == EW'(e)) ? door_open[e] : car_door_s[i];
      end
    end
  end

  // Per-car boarding arbiter: one board per car per cycle, lowest index first, only below capacity.
  always_comb begin
    grant_s = '0;
    taken_s = 1'b0;
    for (int e = 0; e < ELEVATORS; e++) begin
      taken_s = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        if (req_s[i] && (car_s[i] == EW'(e)) && (count_r[e] < CW'(CAP)) && !taken_s) begin
          grant_s[i] = 1'b1;
          taken_s    = 1'b1;
        end else begin
          grant_s[i] = grant_s[i];
        end
      end
    end
  end

  // Next rider count per car: +1 per board, -1 per alight.
  always_comb begin
    for (int e = 0; e < ELEVATORS; e++) begin
      count_nxt_s[e] = count_r[e];
      for (int i = 0; i < SLOTS; i++) begin
        count_nxt_s[e] = count_nxt_s[e]
                       + ((grant_s[i]  && (car_s[i] == EW'(e))) ? CW'(1) : CW'(0))
                       - ((alight_s[i] && (car_s[i] == EW'(e))) ? CW'(1) : CW'(0));
      end
    end
  end

  // Count of completed trips this cycle, and the saturating running total.
  always_comb begin
    n_done_s = 8'd0;
    for (int i = 0; i < SLOTS; i++) begin
      n_done_s = n_done_s + (done_s[i] ? 8'd1 : 8'd0);
    end
    dsum_s = {1'b0, delivered_r} + 17'(n_done_s);
  end

  // Hall and car call maps built from the registered slot states.
  always_comb begin
    hall_req = '0;
    car_req  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      for (int e = 0; e < ELEVATORS; e++) begin
        hall_req[e*FLOORS +: FLOORS] = hall_req[e*FLOORS +: FLOORS]
          | (((st_s[i] == P_WAIT) && (car_s[i] == EW'(e))) ? (FLOORS'(1) << orig_s[i]) : FLOORS'(0));
        car_req[e*FLOORS +: FLOORS]  = car_req[e*FLOORS +: FLOORS]
          | (((st_s[i] == P_RIDE) && (car_s[i] == EW'(e))) ? (FLOORS'(1) << dest_s[i]) : FLOORS'(0));
      end
    end
  end

  // Rider counters: update in SIM, hold in PAUSE, clear in START/ENDING.
  always_ff @(posedge clk) begin
    for (int e = 0; e < ELEVATORS; e++) begin
      if (rst) begin
        count_r[e] <= '0;
      end else begin
        case (sim_s)
          SIM_RUN:   count_r[e] <= count_nxt_s[e];
          SIM_PAUSE: count_r[e] <= count_r[e];
          default:   count_r[e] <= '0;
        endcase
      end
    end
  end

  // Delivered counter: saturating add in SIM, cleared in START, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      delivered_r <= 16'd0;
    end else begin
      case (sim_s)
        SIM_RUN:   delivered_r <= dsum_s[16] ? 16'hFFFF : dsum_s[15:0];
        SIM_START: delivered_r <= 16'd0;
        default:   delivered_r <= delivered_r;
      endcase
    end
  end

endmodule

// File: tb/tb_passenger_pool.sv
// Directed self-checking bench for passenger_pool with default parameters.
module tb_passenger_pool;

  localparam int XW = 10;
  localparam int FW = 3;

  logic        clk;
  logic        rst;
  logic [1:0]  sim_state;
  logic [1:0]  sim_speed;
  logic        tick;
  logic        spawn_en;
  logic [21:0] rnd;
  logic [5:0]  elev_floor;
  logic [1:0]  door_open;
  logic [79:0] xpos;
  logic [23:0] ypos;
  logic [7:0]  slot_active;
  logic [11:0] hall_req;
  logic [11:0] car_req;
  logic [5:0]  rider_count;
  logic [15:0] delivered;

  int n_checks;
  int n_pass;

  passenger_pool dut (
    .clk        (clk),
    .rst        (rst),
    .sim_state  (sim_state),
    .sim_speed  (sim_speed),
    .tick       (tick),
    .spawn_en   (spawn_en),
    .rnd        (rnd),
    .elev_floor (elev_floor),
    .door_open  (door_open),
    .xpos       (xpos),
    .ypos       (ypos),
    .slot_active(slot_active),
    .hall_req   (hall_req),
    .car_req    (car_req),
    .rider_count(rider_count),
    .delivered  (delivered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance n clock edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slot_x(input int i);
    return 32'(xpos[i*XW +: XW]);
  endfunction

  function automatic logic [31:0] slot_y(input int i);
    return 32'(ypos[i*FW +: FW]);
  endfunction

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    sim_state  = 2'd1;
    sim_speed  = 2'd3;
    tick       = 1'b0;
    spawn_en   = 1'b0;
    rnd        = 22'd0;
    elev_floor = 6'd0;
    door_open  = 2'b00;
    step(2);
    rst = 1'b0;
    check("rst_active", 32'(slot_active), 32'd0);
    check("rst_x", {31'd0, |xpos}, 32'd0);
    check("rst_deliv", 32'(delivered), 32'd0);

    // Spawn: orig 2, dest offset 0 (dest 3), car 1, x 0, exit left.
    rnd      = 22'h010002;
    spawn_en = 1'b1;
    step(1);
    spawn_en = 1'b0;
    check("spawn_active", 32'(slot_active), 32'h01);
    check("spawn_x", slot_x(0), 32'd0);
    check("spawn_y", slot_y(0), 32'd2);
    check("spawn_hall", 32'(hall_req), 32'd0);

    // Walk to car-1 door at 340, speed 3.
    tick = 1'b1;
    step(113);
    check("walk113_x", slot_x(0), 32'd339);
    check("walk113_hall", 32'(hall_req), 32'd0);
    step(1);
    check("walk114_x", slot_x(0), 32'd340);
    check("walk114_hall", 32'(hall_req), 32'h100);
    tick = 1'b0;

    // Second passenger from the right edge toward car-0 door at 300.
    rnd      = 22'h100000;
    spawn_en = 1'b1;
    step(1);
    spawn_en = 1'b0;
    check("spawn1_active", 32'(slot_active), 32'h03);
    check("spawn1_x", slot_x(1), 32'd639);
    tick = 1'b1;
    step(5);
    check("walk1_x", slot_x(1), 32'd624);

    // PAUSE freezes walking and ignores spawns.
    sim_state = 2'd2;
    spawn_en  = 1'b1;
    step(10);
    check("pause_x", slot_x(1), 32'd624);
    check("pause_active", 32'(slot_active), 32'h03);
    spawn_en  = 1'b0;
    tick      = 1'b0;
    sim_state = 2'd1;

    // Slot 0 boards car 1 at floor 2.
    elev_floor = {3'd2, 3'd0};
    door_open  = 2'b10;
    step(1);
    check("board_count", 32'(rider_count), 32'd8);
    check("board_carreq", 32'(car_req), 32'h200);
    check("board_hall", 32'(hall_req), 32'd0);
    door_open  = 2'b00;
    elev_floor = {3'd3, 3'd0};
    step(1);
    check("ride_y", slot_y(0), 32'd3);
    door_open = 2'b10;
    step(1);
    check("alight_count", 32'(rider_count), 32'd0);
    check("alight_carreq", 32'(car_req), 32'd0);
    door_open = 2'b00;

    // Walk out 340 -> 45 at speed 3.
    tick = 1'b1;
    step(98);
    check("out98_x", slot_x(0), 32'd46);
    check("out98_deliv", 32'(delivered), 32'd0);
    step(1);
    check("out99_active", 32'(slot_active), 32'h02);
    check("out99_deliv", 32'(delivered), 32'd1);
    check("out99_x0", slot_x(0), 32'd0);
    check("out99_x1", slot_x(1), 32'd327);
    sim_speed = 2'd0;
    step(5);
    check("speed0_x1", slot_x(1), 32'd327);
    tick      = 1'b0;
    sim_speed = 2'd3;

    // ENDING clears slots and keeps delivered; START clears delivered.
    sim_state = 2'd3;
    step(1);
    check("end_active", 32'(slot_active), 32'd0);
    check("end_deliv", 32'(delivered), 32'd1);
    check("end_x1", slot_x(1), 32'd0);
    sim_state = 2'd0;
    step(1);
    check("start_deliv", 32'(delivered), 32'd0);
    sim_state = 2'd1;

    // Five passengers for car 0 at floor 2.
    rnd      = 22'h000002;
    spawn_en = 1'b1;
    step(5);
    spawn_en = 1'b0;
    check("five_active", 32'(slot_active), 32'h1F);
    tick = 1'b1;
    step(100);
    tick = 1'b0;
    check("five_hall", 32'(hall_req), 32'h004);
    elev_floor = {3'd0, 3'd2};
    door_open  = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check($sformatf("cap_count%0d", k), 32'(rider_count), (k > 4) ? 32'd4 : 32'(k));
    end
    check("cap_hall", 32'(hall_req), 32'h004);
    check("cap_carreq", 32'(car_req), 32'h008);

    // Fill remaining slots, then further spawns are dropped.
    rnd      = 22'h100002;
    spawn_en = 1'b1;
    step(3);
    check("full_active", 32'(slot_active), 32'hFF);
    check("full_x7", slot_x(7), 32'd639);
    rnd = 22'h000002;
    step(3);
    spawn_en = 1'b0;
    check("drop_active", 32'(slot_active), 32'hFF);
    check("drop_x5", slot_x(5), 32'd639);

    // Reset while riders are aboard.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mrst_active", 32'(slot_active), 32'd0);
    check("mrst_x", {31'd0, |xpos}, 32'd0);
    check("mrst_y", {31'd0, |ypos}, 32'd0);
    check("mrst_count", 32'(rider_count), 32'd0);
    check("mrst_hall", 32'(hall_req), 32'd0);
    check("mrst_carreq", 32'(car_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
